fifo_buffer: RTL and testbench

- Synchronous FIFO sitting directly downstream of the 2:1 mux stage; accepts the mux's 8-bit data word plus valid, and buffers it for the next consumer.
- The mux's valid output drives push. The consumer drives pop.
- Provides full/empty and almost-full/almost-empty flags for backpressure and flow control, plus a sticky error flag for overflow/underflow.

---
 rtl/fifo_buffer.sv | 124 ++++++++++++
 tb/tb_fifo_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous FIFO placed after the 2:1 mux stage.
// Registered read data with one-cycle latency and zero output when no word is popped.
// Occupancy-based full/empty/almost flags and a sticky overflow/underflow error flag.
// Optional build macro FIFO_BUFFER_COUNT_EN adds a 'count' output that mirrors occupancy.
module fifo_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
`ifdef FIFO_BUFFER_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(ALMOST_FULL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(ALMOST_EMPTY);

    // Storage is never reset; only the pointers and occupancy define validity.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;
    logic                  push_ok, pop_ok;

    // Status flags come straight from the occupancy register.
    assign full         = (occ_q == FULL_CNT);
    assign empty        = (occ_q == '0);
    assign almost_full  = (occ_q >= AF_CNT);
    assign almost_empty = (occ_q <= AE_CNT);

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;

`ifdef FIFO_BUFFER_COUNT_EN
    assign count = occ_q;
`endif

    // Acceptance: a pop needs data; a push needs space, or a concurrent pop freeing
    // a slot when full. There is no empty bypass, so push+pop on empty only pushes.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop);
    end

    // Next-state computation for pointers, occupancy, output register and error flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        error_d     = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            // Reads the pre-edge contents, so a full push+pop at the same slot
            // still returns the oldest word.
            data_out_d  = mem[rd_ptr_q];
            valid_out_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        if (push_ok && !pop_ok) begin
            occ_d = occ_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            occ_d = occ_q - 1'b1;
        end

        // Overflow: push while full without a pop. Underflow: pop while empty.
        if ((push && full && !pop) || (pop && empty)) begin
            error_d = 1'b1;
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Control state and registered outputs, cleared asynchronously by reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: table-driven vectors with a queue scoreboard for fifo_buffer.
module tb_fifo_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       push;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
`ifdef FIFO_BUFFER_COUNT_EN
    logic [2:0] count;
`endif

    fifo_buffer #(
        .DATA_WIDTH  (8),
        .DEPTH       (4),
        .ALMOST_FULL (3),
        .ALMOST_EMPTY(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .push        (push),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .error       (error)
`ifdef FIFO_BUFFER_COUNT_EN
        ,
        .count       (count)
`endif
    );

    always #5 clk = ~clk;

    // Flag patterns {full, empty, almost_full, almost_empty} per occupancy (AF=3, AE=1).
    localparam logic [3:0] O0 = 4'b0101;
    localparam logic [3:0] O1 = 4'b0001;
    localparam logic [3:0] O2 = 4'b0000;
    localparam logic [3:0] O3 = 4'b0010;
    localparam logic [3:0] O4 = 4'b1010;

    typedef struct {
        logic       rst;
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [4:0] exp_flags;  // {full, empty, almost_full, almost_empty, error}
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model_q[$];   // reference FIFO contents
    logic [7:0] sb_q[$];      // expected output words
    int         total  = 0;
    int         passed = 0;

    task automatic add(input logic r, input logic p, input logic q,
                       input logic [7:0] d, input logic [3:0] o, input logic e);
        vec_t v;
        v.rst = r; v.push = p; v.pop = q; v.din = d; v.exp_flags = {o, e};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; data_in = 8'h00;
        reset = 1'b0;
        #2;
        check("reset_out", {7'd0, valid_out, data_out}, 16'h0);
        check("reset_flags", {11'd0, full, empty, almost_full, almost_empty, error}, {11'd0, O0, 1'b0});
        $display("reset: valid=%0b data=0x%02h flags=%05b", valid_out, data_out,
                 {full, empty, almost_full, almost_empty, error});
        @(negedge clk);
        reset = 1'b1;
        model_q.delete();
        sb_q.delete();
    endtask

    task automatic apply(input vec_t v);
        bit         pop_ok, push_ok;
        logic [7:0] exp_d;
        if (v.rst) do_reset();
        @(negedge clk);
        push = v.push; pop = v.pop; data_in = v.din;
        pop_ok  = v.pop && (model_q.size() > 0);
        push_ok = v.push && ((model_q.size() < 4) || v.pop);
        if (pop_ok)  sb_q.push_back(model_q.pop_front());
        if (push_ok) model_q.push_back(v.din);
        @(posedge clk);
        #1;
        if (pop_ok) begin
            exp_d = sb_q.pop_front();
            check("pop_data", {7'd0, valid_out, data_out}, {7'd0, 1'b1, exp_d});
        end else begin
            check("no_pop_out", {7'd0, valid_out, data_out}, 16'h0);
        end
        check("flags", {11'd0, full, empty, almost_full, almost_empty, error}, {11'd0, v.exp_flags});
        $display("push=%0b pop=%0b din=0x%02h -> valid=%0b dout=0x%02h flags=%05b exp=%05b",
                 v.push, v.pop, v.din, valid_out, data_out,
                 {full, empty, almost_full, almost_empty, error}, v.exp_flags);
    endtask

    initial begin
        vec_t v;
        clk = 1'b0; reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

        // Basic push x3 / pop x3
        add(1, 1, 0, 8'hA1, O1, 0);
        add(0, 1, 0, 8'hB2, O2, 0);
        add(0, 1, 0, 8'hC3, O3, 0);
        add(0, 0, 1, 8'h00, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 0, 1, 8'h00, O0, 0);
        add(0, 0, 0, 8'h00, O0, 0);
        // Fill, overflow drop, drain
        add(1, 1, 0, 8'h01, O1, 0);
        add(0, 1, 0, 8'h02, O2, 0);
        add(0, 1, 0, 8'h03, O3, 0);
        add(0, 1, 0, 8'h04, O4, 0);
        add(0, 1, 0, 8'hFF, O4, 1);
        add(0, 0, 1, 8'h00, O3, 1);
        add(0, 0, 1, 8'h00, O2, 1);
        add(0, 0, 1, 8'h00, O1, 1);
        add(0, 0, 1, 8'h00, O0, 1);
        // Full with simultaneous push+pop
        add(1, 1, 0, 8'h11, O1, 0);
        add(0, 1, 0, 8'h22, O2, 0);
        add(0, 1, 0, 8'h33, O3, 0);
        add(0, 1, 0, 8'h44, O4, 0);
        add(0, 1, 1, 8'h55, O4, 0);
        add(0, 1, 1, 8'h55, O4, 0);
        add(0, 1, 1, 8'h55, O4, 0);
        add(0, 0, 1, 8'h00, O3, 0);
        add(0, 0, 1, 8'h00, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 0, 1, 8'h00, O0, 0);
        // Underflow, sticky error, push+pop on empty, reset clears error
        add(1, 0, 1, 8'h00, O0, 1);
        add(0, 1, 0, 8'h66, O1, 1);
        add(0, 0, 1, 8'h00, O0, 1);
        add(0, 1, 1, 8'h77, O1, 1);
        add(0, 0, 1, 8'h00, O0, 1);
        add(1, 0, 0, 8'h00, O0, 0);
        // Interleaved traffic wrapping both pointers
        add(1, 1, 0, 8'h10, O1, 0);
        add(0, 1, 0, 8'h11, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 1, 0, 8'h12, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 1, 0, 8'h13, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 1, 1, 8'h14, O1, 0);
        add(0, 1, 0, 8'h15, O2, 0);
        add(0, 0, 1, 8'h00, O1, 0);
        add(0, 0, 1, 8'h00, O0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Asynchronous reset mid-cycle with two entries stored and valid_out high
        v.rst = 1; v.push = 1; v.pop = 0; v.din = 8'hD1; v.exp_flags = {O1, 1'b0}; apply(v);
        v.rst = 0; v.din = 8'hD2; v.exp_flags = {O2, 1'b0}; apply(v);
        v.din = 8'hD3; v.exp_flags = {O3, 1'b0}; apply(v);
        v.push = 0; v.pop = 1; v.din = 8'h00; v.exp_flags = {O2, 1'b0}; apply(v);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_out", {7'd0, valid_out, data_out}, 16'h0);
        check("async_rst_flags", {11'd0, full, empty, almost_full, almost_empty, error}, {11'd0, O0, 1'b0});
        $display("async reset: valid=%0b data=0x%02h empty=%0b", valid_out, data_out, empty);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        reset = 1'b1;
        model_q.delete();
        sb_q.delete();
        v.rst = 0; v.push = 0; v.pop = 1; v.exp_flags = {O0, 1'b1}; apply(v);

        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
